bm_mult_share_sched: RTL and testbench
======================================

// Module: bm_mult_share_sched
// PURPOSE
//  Round-robin scheduler sharing one registered WIDTHxWIDTH unsigned multiplier among NREQ requesters.
//  Each requester presents operands with valid/ready. The scheduler grants one requester per cycle.
//  Operands, with the requester index as a tag, flow through a MUL_LAT-deep pipeline.
//  The tagged product is returned on a single result port with backpressure.
//  Sits between the benchmark operand sources and the multiply datapath.
// PARAMETERS
//  WIDTH    8  operand width; product width is 2*WIDTH
//  NREQ     4  number of requesters (2..8); ID width IDW = clog2(NREQ)
//  MUL_LAT  2  accept-to-result latency in cycles (1..4)
// PORTS
//  clock      in   1             rising-edge clock
//  reset      in   1             asynchronous, active-high reset
//  req_valid  in   NREQ          requester i has operands pending
//  req_a      in   NREQ*WIDTH    operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH    operand B, same packing
//  req_ready  out  NREQ          one-hot; requester i accepted this cycle
//  res_valid  out  1             result present on res_data/res_id
//  res_id     out  IDW           index of the requester that owns the result
//  res_data   out  2*WIDTH       unsigned product a*b
//  res_ready  in   1             consumer takes the result
//  ops_done   out  16            count of results consumed (res_valid & res_ready)
// BEHAVIOUR
//  Reset (async): all pipeline valid bits 0, rr_ptr=0, res_valid=0, res_id=0, res_data=0, ops_done=0.
//    In-flight operations are discarded; no result is ever produced for them.
//  advance = ~res_valid | res_ready.
//    On advance, all MUL_LAT stages shift by one.
//    Otherwise the whole pipeline holds (global stall); bubbles also hold.
//  Arbitration (combinational, only when advance=1):
//    winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//    req_ready[winner]=1; all other bits 0.
//    If no req_valid is set or advance=0, req_ready=0.
//  Transfer: req_valid[i] & req_ready[i].
//    Stage 1 captures {valid=1, id=i, product=a_i*b_i}. Full 2*WIDTH result, no truncation.
//    rr_ptr <= (i+1) mod NREQ. Wrap from NREQ-1 to 0.
//  No transfer while advancing: stage 1 captures a bubble (valid=0); rr_ptr unchanged.
//  Latency: a transfer at edge T gives res_valid=1 after edge T+MUL_LAT-1, if no stall.
//    Each stall cycle adds one cycle.
//  Ordering: results leave in acceptance order. Throughput: one result per cycle when unstalled.
//  Output stability: while res_valid & ~res_ready, res_id and res_data hold.
//  req_ready depends combinationally on req_valid and res_ready.
//    Requesters must not make req_valid depend on req_ready.
//  res_data and res_id keep their last values when res_valid=0.
//  ops_done increments on each res_valid & res_ready. It wraps 16'hFFFF -> 0.
//  Simultaneous events:
//    The output is consumed and a new request is accepted in the same cycle: both happen.
//    res_ready=1 while res_valid=0: no effect.
//  Operand sign: unsigned. Example: 8'hFF*8'hFF = 16'hFE01.
// TESTING
//  T1 reset: assert reset mid-stream with 2 ops in flight
//     -> res_valid=0 and ops_done=0 immediately; no stale result after release.
//  T2 single: req0 a=3 b=5, res_ready=1
//     -> res_valid MUL_LAT cycles later, res_id=0, res_data=15, ops_done=1.
//  T3 fairness: all 4 req_valid held high with distinct operands, res_ready=1
//     -> grants 0,1,2,3,0,... one per cycle; results come back in that order.
//  T4 stall: res_ready=0 for 5 cycles with the pipeline full
//     -> req_ready=0 throughout, res_data stable.
//     Release res_ready -> results resume with none lost or duplicated.
//  T5 width/wrap: a=b=8'hFF -> 16'hFE01.
//     Preload ops_done near 16'hFFFF via 65536 consumes -> wraps to 0.
//  T6 sparse: only req2 valid with rr_ptr=3 -> req2 granted, rr_ptr becomes 3.

Source files
------------

// File: rtl/bm_mult_share_sched.sv
// Round-robin scheduler sharing one pipelined unsigned multiplier
// among NREQ valid/ready requesters; tagged products leave in order.
module bm_mult_share_sched #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [2*WIDTH-1:0]    res_data,
  input  logic                  res_ready,
  output logic [15:0]           ops_done
);

  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);

  logic               advance;
  logic               gnt_any;
  logic               xfer;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     gnt_idx;
  logic [IDW:0]       scan;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [2*WIDTH-1:0] prod_in;
  logic [MUL_LAT-1:0] vld_q;
  logic [IDW-1:0]     id_q   [MUL_LAT];
  logic [2*WIDTH-1:0] prod_q [MUL_LAT];

  assign res_valid = vld_q[MUL_LAT-1];
  assign res_id    = id_q[MUL_LAT-1];
  assign res_data  = prod_q[MUL_LAT-1];
  assign advance   = ~res_valid | res_ready;

  // Scan farthest-first so the requester nearest rr_ptr is written last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan >= NREQ_W)
        scan = scan - NREQ_W;
      if (req_valid[scan[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan[IDW-1:0];
      end
    end
  end

  assign xfer = advance & gnt_any;

  always_comb begin
    req_ready = '0;
    if (xfer)
      req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign prod_in = {{WIDTH{1'b0}}, a_sel} * {{WIDTH{1'b0}}, b_sel};

  // Payload only moves with a valid entry, so the output holds on bubbles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q    <= '0;
      rr_ptr   <= '0;
      ops_done <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        id_q[i]   <= '0;
        prod_q[i] <= '0;
      end
    end else begin
      if (res_valid && res_ready)
        ops_done <= ops_done + 16'd1;
      if (advance) begin
        vld_q[0] <= xfer;
        if (xfer) begin
          id_q[0]   <= gnt_idx;
          prod_q[0] <= prod_in;
          rr_ptr    <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + IDW'(1);
        end
        for (int i = 1; i < MUL_LAT; i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) begin
            id_q[i]   <= id_q[i-1];
            prod_q[i] <= prod_q[i-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bm_mult_share_sched.sv
// Bench for bm_mult_share_sched: queue-based reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_bm_mult_share_sched;

  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int MUL_LAT = 2;
  localparam int IDW     = $clog2(NREQ);

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [2*WIDTH-1:0]    res_data;
  logic                  res_ready = 1'b1;
  logic [15:0]           ops_done;

  int errors = 0;
  int checks = 0;

  bm_mult_share_sched #(
    .WIDTH(WIDTH), .NREQ(NREQ), .MUL_LAT(MUL_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .res_ready(res_ready), .ops_done(ops_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: in-flight items with a count of pipeline moves since acceptance.
  typedef struct {
    int          id;
    logic [15:0] p;
    int          age;
  } item_t;

  item_t       q[$];
  int          m_rr;
  int          m_gnt;
  bit          m_vis;
  bit          m_adv;
  logic [15:0] m_ops;
  int          m_last_id;
  logic [15:0] m_last_p;
  logic [15:0] m_pa;
  logic [15:0] m_pb;
  logic [3:0]  m_rdy;
  int          m_j;

  task automatic model_clear();
    q.delete();
    m_rr      = 0;
    m_ops     = '0;
    m_last_id = 0;
    m_last_p  = '0;
    m_gnt     = -1;
    m_vis     = 0;
    m_adv     = 0;
  endtask

  always begin
    @(negedge clock);
    if (reset) begin
      model_clear();
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_ops_done", 32'(ops_done), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
    end else begin
      m_vis = q.size() > 0 && q[0].age == MUL_LAT-1;
      if (m_vis) begin
        m_last_id = q[0].id;
        m_last_p  = q[0].p;
      end
      m_adv = !m_vis || res_ready;
      m_gnt = -1;
      if (m_adv) begin
        for (int k = 0; k < NREQ; k++) begin
          m_j = (m_rr + k) % NREQ;
          if (req_valid[m_j]) begin
            m_gnt = m_j;
            break;
          end
        end
      end
      m_rdy = '0;
      if (m_gnt >= 0) begin
        m_rdy[m_gnt] = 1'b1;
        m_pa = 16'(req_a[m_gnt*WIDTH +: WIDTH]);
        m_pb = 16'(req_b[m_gnt*WIDTH +: WIDTH]);
      end
      chk("req_ready", 32'(req_ready), 32'(m_rdy));
      chk("res_valid", 32'(res_valid), 32'(m_vis));
      chk("res_id", 32'(res_id), 32'(m_last_id));
      chk("res_data", 32'(res_data), 32'(m_last_p));
      chk("ops_done", 32'(ops_done), 32'(m_ops));
    end
    @(posedge clock);
    if (reset) begin
      model_clear();
    end else begin
      if (m_vis && res_ready) begin
        void'(q.pop_front());
        m_ops = m_ops + 16'd1;
      end
      if (m_adv)
        foreach (q[i]) q[i].age++;
      if (m_gnt >= 0) begin
        q.push_back('{id: m_gnt, p: m_pa * m_pb, age: 0});
        m_rr = (m_gnt + 1) % NREQ;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    res_ready = 1'b1;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  logic [15:0] ptab [4] = '{16'd2, 16'd6, 16'd12, 16'd20};

  initial begin
    do_reset();
    chk("init_res_valid", 32'(res_valid), 32'd0);
    chk("init_ops_done", 32'(ops_done), 32'd0);

    // T2: single request
    req_a = {8'd0, 8'd0, 8'd0, 8'd3};
    req_b = {8'd0, 8'd0, 8'd0, 8'd5};
    req_valid = 4'b0001;
    #1;
    chk("t2_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    repeat (MUL_LAT-1) step();
    chk("t2_valid", 32'(res_valid), 32'd1);
    chk("t2_id", 32'(res_id), 32'd0);
    chk("t2_data", 32'(res_data), 32'd15);
    step();
    chk("t2_ops", 32'(ops_done), 32'd1);
    chk("t2_valid_off", 32'(res_valid), 32'd0);

    // T1: reset with two ops in flight
    req_valid = 4'b0011;
    repeat (2) step();
    req_valid = '0;
    reset = 1'b1;
    #1;
    chk("t1_valid_now", 32'(res_valid), 32'd0);
    chk("t1_ops_now", 32'(ops_done), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t1_no_stale", 32'(res_valid), 32'd0);
      step();
    end

    // T3: fairness with all requesters active
    do_reset();
    req_a = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b = {8'd5, 8'd4, 8'd3, 8'd2};
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("t3_grant", 32'(req_ready), 32'(1) << (k % 4));
      if (k >= MUL_LAT) begin
        chk("t3_id", 32'(res_id), 32'((k - MUL_LAT) % 4));
        chk("t3_data", 32'(res_data), 32'(ptab[(k - MUL_LAT) % 4]));
      end
      step();
    end

    // T4: stall with full pipeline
    res_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_ready", 32'(req_ready), 32'd0);
      chk("t4_valid", 32'(res_valid), 32'd1);
      chk("t4_id", 32'(res_id), 32'd2);
      chk("t4_data", 32'(res_data), 32'd12);
      step();
    end
    res_ready = 1'b1;
    #1;
    chk("t4_resume_grant", 32'(req_ready), 32'h1);
    step();
    chk("t4_next_id", 32'(res_id), 32'd3);
    chk("t4_next_data", 32'(res_data), 32'd20);
    step();
    chk("t4_next2_id", 32'(res_id), 32'd0);
    chk("t4_next2_data", 32'(res_data), 32'd2);
    req_valid = '0;
    repeat (MUL_LAT + 2) step();

    // T6: sparse request with rr_ptr past the requester
    do_reset();
    req_valid = 4'b0100;
    #1;
    chk("t6_first", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step();
    req_valid = 4'b0100;
    #1;
    chk("t6_wrap", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b1111;
    #1;
    chk("t6_ptr3", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    repeat (MUL_LAT + 2) step();

    // T5: full-width product, then ops_done wrap
    do_reset();
    req_a = {8'h00, 8'h00, 8'hFF, 8'h00};
    req_b = {8'h00, 8'h00, 8'hFF, 8'h00};
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    repeat (MUL_LAT-1) step();
    chk("t5_valid", 32'(res_valid), 32'd1);
    chk("t5_id", 32'(res_id), 32'd1);
    chk("t5_data", 32'(res_data), 32'hFE01);
    repeat (2) step();
    do_reset();
    req_valid = 4'b1111;
    repeat (65536) step();
    req_valid = '0;
    chk("t5_ops_fffe", 32'(ops_done), 32'hFFFE);
    step();
    chk("t5_ops_ffff", 32'(ops_done), 32'hFFFF);
    step();
    chk("t5_ops_wrap", 32'(ops_done), 32'h0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
